tetris_input_ctrl: RTL and testbench

- Command initiator for the tetris game engine; produces the engine's `ctrl` command stream and `bar_mask` from player buttons, a gravity timer and garbage-bar requests.
- Observes the engine's `state` to apply a one-command-in-flight handshake, so the engine never misses or double-takes a command.
- Sits between the debounced button/UART front end and the engine; imports `enum_type::*` for `state_type`.

---
 rtl/enum_type.sv | 27 ++
 rtl/das_repeat.sv | 45 ++++
 rtl/tetris_input_ctrl.sv | 176 +++++++++++++++++
 tb/tb_tetris_input_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enum_type.sv
// Shared engine state/command encoding used by the tetris engine and its input controller.
package enum_type;

    typedef enum logic [3:0] {
        NONE       = 4'd0,
        INIT       = 4'd1,
        WAIT       = 4'd2,
        GEN        = 4'd3,
        CHECK      = 4'd4,
        CLEAR      = 4'd5,
        END        = 4'd6,
        LEFT       = 4'd7,
        RIGHT      = 4'd8,
        DOWN       = 4'd9,
        DROP       = 4'd10,
        ROTATE     = 4'd11,
        ROTATE_REV = 4'd12,
        HOLD       = 4'd13,
        BAR        = 4'd14
    } state_type;

    // INIT and END are the "no game running" states where buttons only restart the engine.
    function automatic logic is_idle_state(input state_type s);
        return (s == INIT) || (s == END);
    endfunction

endpackage

// File: rtl/das_repeat.sv
// Rising-edge detect plus delayed auto-repeat for one held button; pend_set pulses on the edge and each repeat.
module das_repeat #(
    parameter int DAS_DELAY = 17_000_000,
    parameter int DAS_RATE  = 5_000_000,
    parameter int CW        = 26
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    input  logic clear,
    output logic pend_set
);

    localparam logic [CW-1:0] FIRE_AT = CW'(DAS_DELAY - 1);
    localparam logic [CW-1:0] RELOAD  = CW'(DAS_DELAY - DAS_RATE);

    logic          btn_q;
    logic [CW-1:0] cnt;
    logic          rise;
    logic          fire;

    // cnt==0 means idle; the edge cycle counts as 1, so the first repeat lands DAS_DELAY-1 edges later
    assign rise     = btn & ~btn_q;
    assign fire     = btn & ~clear & (cnt == FIRE_AT);
    assign pend_set = rise | fire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q <= 1'b0;
            cnt   <= '0;
        end else begin
            btn_q <= btn;
            if (clear || !btn) begin
                cnt <= '0;
            end else if (rise) begin
                cnt <= CW'(1);
            end else if (fire) begin
                cnt <= RELOAD;
            end else if (cnt != '0) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Turns buttons, gravity and garbage-bar requests into a one-command-in-flight ctrl stream for the engine.
module tetris_input_ctrl
    import enum_type::*;
#(
    parameter int GRAV_BASE = 50_000_000,
    parameter int GRAV_STEP = 4_000_000,
    parameter int GRAV_MIN  = 5_000_000,
    parameter int DAS_DELAY = 17_000_000,
    parameter int DAS_RATE  = 5_000_000,
    parameter int CW        = 26
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_drop,
    input  logic       btn_rot,
    input  logic       btn_rot_rev,
    input  logic       btn_hold,
    input  logic       bar_req,
    input  logic [9:0] bar_mask_in,
    input  logic [3:0] level,
    input  state_type  state,
    output state_type  ctrl,
    output logic [9:0] bar_mask,
    output logic       bar_drop
);

    localparam int GW = CW + 4;
    localparam logic [GW-1:0] STEP_W = GW'(GRAV_STEP);
    localparam logic [GW-1:0] BASE_W = GW'(GRAV_BASE);
    localparam logic [GW-1:0] SPAN_W = GW'(GRAV_BASE - GRAV_MIN);

    logic          halted;
    logic          set_left, set_right, set_down;
    logic [3:0]    btn_q;
    logic          rise_hold, rise_drop, rise_rot, rise_rot_rev, any_rise;
    logic          pend_hold, pend_drop, pend_rot, pend_rot_rev;
    logic          pend_left, pend_right, pend_down, grav_pend;
    logic          busy, issue, restart;
    state_type     state_q, sel, taken;
    logic [GW-1:0] grav_dec;
    logic [CW-1:0] grav_period, grav_cnt;
    logic          grav_fire;
    logic          bar_valid;
    logic [9:0]    bar_buf;

    assign halted = is_idle_state(state);

    das_repeat #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE), .CW(CW)) u_das_left (
        .clk(clk), .reset_n(reset_n), .btn(btn_left), .clear(halted), .pend_set(set_left)
    );
    das_repeat #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE), .CW(CW)) u_das_right (
        .clk(clk), .reset_n(reset_n), .btn(btn_right), .clear(halted), .pend_set(set_right)
    );
    das_repeat #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE), .CW(CW)) u_das_down (
        .clk(clk), .reset_n(reset_n), .btn(btn_down), .clear(halted), .pend_set(set_down)
    );

    assign rise_hold    = btn_hold    & ~btn_q[3];
    assign rise_drop    = btn_drop    & ~btn_q[2];
    assign rise_rot     = btn_rot     & ~btn_q[1];
    assign rise_rot_rev = btn_rot_rev & ~btn_q[0];
    // While halted the repeat units are cleared, so their outputs here are pure rising edges
    assign any_rise = rise_hold | rise_drop | rise_rot | rise_rot_rev
                    | set_left | set_right | set_down;

    // Saturate before subtracting so high levels cannot wrap the period
    assign grav_dec    = GW'(level) * STEP_W;
    assign grav_period = (grav_dec >= SPAN_W) ? CW'(GRAV_MIN) : CW'(BASE_W - grav_dec);
    assign grav_fire   = !halted && (state != GEN) && (grav_cnt >= grav_period - 1'b1);

    always_comb begin
        sel = NONE;
        if (pend_hold)                   sel = HOLD;
        else if (pend_drop)              sel = DROP;
        else if (pend_rot)               sel = ROTATE;
        else if (pend_rot_rev)           sel = ROTATE_REV;
        else if (pend_left)              sel = LEFT;
        else if (pend_right)             sel = RIGHT;
        else if (pend_down || grav_pend) sel = DOWN;
        else if (bar_valid)              sel = BAR;
    end

    assign issue   = (state == WAIT) && !busy && (sel != NONE);
    assign restart = halted && !busy && any_rise;

    always_comb begin
        taken = NONE;
        if (issue) taken = sel;
    end

    // A set arriving on the same edge as the issue-clear keeps the flag, so the command goes out again later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q        <= '0;
            pend_hold    <= 1'b0;
            pend_drop    <= 1'b0;
            pend_rot     <= 1'b0;
            pend_rot_rev <= 1'b0;
            pend_left    <= 1'b0;
            pend_right   <= 1'b0;
            pend_down    <= 1'b0;
            grav_pend    <= 1'b0;
        end else begin
            btn_q <= {btn_hold, btn_drop, btn_rot, btn_rot_rev};
            if (halted) begin
                pend_hold    <= 1'b0;
                pend_drop    <= 1'b0;
                pend_rot     <= 1'b0;
                pend_rot_rev <= 1'b0;
                pend_left    <= 1'b0;
                pend_right   <= 1'b0;
                pend_down    <= 1'b0;
                grav_pend    <= 1'b0;
            end else begin
                pend_hold    <= rise_hold    | (pend_hold    & (taken != HOLD));
                pend_drop    <= rise_drop    | (pend_drop    & (taken != DROP));
                pend_rot     <= rise_rot     | (pend_rot     & (taken != ROTATE));
                pend_rot_rev <= rise_rot_rev | (pend_rot_rev & (taken != ROTATE_REV));
                pend_left    <= set_left     | (pend_left    & (taken != LEFT));
                pend_right   <= set_right    | (pend_right   & (taken != RIGHT));
                pend_down    <= set_down     | (pend_down    & (taken != DOWN));
                grav_pend    <= grav_fire    | (grav_pend    & (taken != DOWN) & (state != GEN));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grav_cnt <= '0;
        end else if (!halted) begin
            if (state == GEN || grav_fire) grav_cnt <= '0;
            else                           grav_cnt <= grav_cnt + 1'b1;
        end
    end

    // busy is released once the engine visibly reacts: leaving WAIT, or any state change while halted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl    <= NONE;
            busy    <= 1'b0;
            state_q <= NONE;
        end else begin
            state_q <= state;
            ctrl    <= restart ? DOWN : taken;
            if (issue || restart) begin
                busy <= 1'b1;
            end else if (halted ? (state != state_q)
                                : (state != WAIT || state_q != WAIT)) begin
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bar_valid <= 1'b0;
            bar_buf   <= '0;
            bar_mask  <= '0;
            bar_drop  <= 1'b0;
        end else begin
            bar_drop <= bar_req & bar_valid;
            if (bar_req && bar_mask_in != '0 && !bar_valid) begin
                bar_valid <= 1'b1;
                bar_buf   <= bar_mask_in;
            end else if (taken == BAR) begin
                bar_valid <= 1'b0;
            end
            if (taken == BAR)                      bar_mask <= bar_buf;
            else if (state != WAIT && state != BAR) bar_mask <= '0;
        end
    end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl with a small stub engine that reacts to each issued command.
module tb_tetris_input_ctrl;
    import enum_type::*;

    localparam logic [6:0] B_HOLD  = 7'b1000000;
    localparam logic [6:0] B_DROP  = 7'b0100000;
    localparam logic [6:0] B_ROT   = 7'b0010000;
    localparam logic [6:0] B_LEFT  = 7'b0000100;
    localparam logic [6:0] B_RIGHT = 7'b0000010;
    localparam logic [6:0] B_DOWN  = 7'b0000001;
    localparam logic [9:0] M1 = 10'b1110111111;
    localparam logic [9:0] M2 = 10'b0000000001;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_left, btn_right, btn_down, btn_drop, btn_rot, btn_rot_rev, btn_hold;
    logic       bar_req;
    logic [9:0] bar_mask_in;
    logic [3:0] level;
    state_type  state;
    state_type  ctrl;
    logic [9:0] bar_mask;
    logic       bar_drop;

    int  vectors     = 0;
    int  miscompares = 0;
    bit  stub_on;
    int  stub_lat;
    int  stub_left;

    always #5 clk = ~clk;

    tetris_input_ctrl #(
        .GRAV_BASE(100), .GRAV_STEP(10), .GRAV_MIN(20),
        .DAS_DELAY(8), .DAS_RATE(3), .CW(26)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
        .btn_drop(btn_drop), .btn_rot(btn_rot), .btn_rot_rev(btn_rot_rev),
        .btn_hold(btn_hold), .bar_req(bar_req), .bar_mask_in(bar_mask_in),
        .level(level), .state(state), .ctrl(ctrl),
        .bar_mask(bar_mask), .bar_drop(bar_drop)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] b);
        {btn_hold, btn_drop, btn_rot, btn_rot_rev, btn_left, btn_right, btn_down} = b;
    endtask

    // Stub engine: takes the command state for one cycle, sits in CHECK, then returns to WAIT
    task automatic stepClock();
        @(posedge clk);
        #1;
        if (stub_on) begin
            if (ctrl != NONE) begin
                state     = ctrl;
                stub_left = stub_lat - 1;
            end else if (stub_left > 0) begin
                state = CHECK;
                stub_left--;
            end else begin
                state = WAIT;
            end
        end
    endtask

    task automatic waitCmd(input int limit, output state_type c, output int n);
        c = NONE;
        n = 0;
        while (n < limit && c == NONE) begin
            stepClock();
            n++;
            c = ctrl;
        end
    endtask

    task automatic genPulse();
        stub_on = 1'b0;
        state   = GEN;
        stepClock();
        state     = WAIT;
        stub_left = 0;
        stub_on   = 1'b1;
    endtask

    initial begin
        state_type c;
        state_type exp_cmd;
        int        n;

        reset_n     = 1'b1;
        applyStimulus(7'b0);
        bar_req     = 1'b0;
        bar_mask_in = '0;
        level       = 4'd0;
        state       = WAIT;
        stub_on     = 1'b0;
        stub_lat    = 2;
        stub_left   = 0;

        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset_ctrl", ctrl, NONE);
        checkOutput("reset_bar_mask", bar_mask, 10'd0);
        checkOutput("reset_bar_drop", bar_drop, 1'b0);
        stepClock();
        #2 reset_n = 1'b1;
        stepClock();
        checkOutput("post_reset_ctrl", ctrl, NONE);

        $display("[TB] left tap");
        stub_lat = 3;
        genPulse();
        applyStimulus(B_LEFT);
        stepClock();
        checkOutput("tap_edge", ctrl, NONE);
        applyStimulus(7'b0);
        stepClock();
        checkOutput("tap_issue", ctrl, LEFT);
        for (int i = 0; i < 10; i++) begin
            stepClock();
            checkOutput("tap_quiet", ctrl, NONE);
        end

        $display("[TB] right auto-repeat");
        stub_lat = 2;
        genPulse();
        applyStimulus(B_RIGHT);
        for (int i = 0; i < 26; i++) begin
            stepClock();
            if (i == 1 || i == 8 || i == 11 || i == 14 || i == 17) exp_cmd = RIGHT;
            else                                                 exp_cmd = NONE;
            checkOutput("das_right", ctrl, exp_cmd);
            if (i == 18) applyStimulus(7'b0);
        end

        $display("[TB] gravity");
        genPulse();
        waitCmd(150, c, n);
        checkOutput("grav0_cmd", c, DOWN);
        checkOutput("grav0_first", n, 101);
        waitCmd(150, c, n);
        checkOutput("grav0_cmd2", c, DOWN);
        checkOutput("grav0_period", n, 100);
        level = 4'd9;
        repeat (3) stepClock();
        genPulse();
        waitCmd(60, c, n);
        checkOutput("grav9_cmd", c, DOWN);
        checkOutput("grav9_first", n, 21);
        waitCmd(60, c, n);
        checkOutput("grav9_period", n, 20);
        repeat (10) stepClock();
        genPulse();
        waitCmd(60, c, n);
        checkOutput("grav_gen_cmd", c, DOWN);
        checkOutput("grav_gen_restart", n, 21);
        level = 4'd0;
        repeat (3) stepClock();

        $display("[TB] priority");
        genPulse();
        applyStimulus(B_HOLD | B_DROP | B_LEFT);
        stepClock();
        applyStimulus(7'b0);
        waitCmd(10, c, n);
        checkOutput("prio_first", c, HOLD);
        checkOutput("prio_first_time", n, 1);
        waitCmd(10, c, n);
        checkOutput("prio_second", c, DROP);
        checkOutput("prio_second_time", n, 3);
        waitCmd(10, c, n);
        checkOutput("prio_third", c, LEFT);
        waitCmd(20, c, n);
        checkOutput("prio_none", c, NONE);

        $display("[TB] garbage bar");
        stub_on = 1'b0;
        state   = GEN;
        stepClock();
        state       = CLEAR;
        bar_req     = 1'b1;
        bar_mask_in = M1;
        applyStimulus(B_DOWN);
        stepClock();
        checkOutput("bar_store_drop", bar_drop, 1'b0);
        bar_mask_in = M2;
        applyStimulus(7'b0);
        stepClock();
        checkOutput("bar_full_drop", bar_drop, 1'b1);
        checkOutput("bar_busy_ctrl", ctrl, NONE);
        bar_req     = 1'b0;
        bar_mask_in = '0;
        stepClock();
        checkOutput("bar_drop_pulse_end", bar_drop, 1'b0);
        state     = WAIT;
        stub_left = 0;
        stub_on   = 1'b1;
        waitCmd(10, c, n);
        checkOutput("bar_down_first", c, DOWN);
        checkOutput("bar_mask_idle", bar_mask, 10'd0);
        waitCmd(10, c, n);
        checkOutput("bar_issue", c, BAR);
        checkOutput("bar_mask_issue", bar_mask, M1);
        stepClock();
        checkOutput("bar_mask_in_bar", bar_mask, M1);
        stepClock();
        checkOutput("bar_mask_cleared", bar_mask, 10'd0);
        bar_req     = 1'b1;
        bar_mask_in = '0;
        stepClock();
        checkOutput("bar_zero_drop", bar_drop, 1'b0);
        bar_req = 1'b0;
        waitCmd(20, c, n);
        checkOutput("bar_zero_none", c, NONE);

        $display("[TB] END/INIT restart");
        stub_on = 1'b0;
        state   = END;
        repeat (2) stepClock();
        applyStimulus(B_ROT);
        stepClock();
        checkOutput("end_restart", ctrl, DOWN);
        applyStimulus(7'b0);
        state = INIT;
        stepClock();
        checkOutput("end_one_cycle", ctrl, NONE);
        stepClock();
        checkOutput("init_idle", ctrl, NONE);
        applyStimulus(B_ROT);
        stepClock();
        checkOutput("init_restart", ctrl, DOWN);
        reset_n = 1'b0;
        #1;
        checkOutput("reset_async_ctrl", ctrl, NONE);
        checkOutput("reset_async_mask", bar_mask, 10'd0);
        applyStimulus(7'b0);
        stepClock();
        checkOutput("reset_hold_ctrl", ctrl, NONE);
        reset_n = 1'b1;
        stepClock();
        checkOutput("reset_release_ctrl", ctrl, NONE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
